reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
Parametrised multi-port register file that generalises the 2-read/1-write file: N read ports, 2 write ports, register 0 hardwired to zero. It adds a per-register busy scoreboard so the decode stage can stall on pending producers. It sits between decode (reads, busy set) and writeback (two retire lanes) in the pipelined processor.

Parameters:
DATA_WIDTH, 32, bits per register
NUM_REGS, 32, register count; power of two, >= 2
NUM_RD, 4, number of read ports (1..8)
REG_NUM_WIDTH, $clog2(NUM_REGS), register index width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous reset, active-low
rdNum  in  NUM_RD*REG_NUM_WIDTH  read indices; port i at [i*REG_NUM_WIDTH +: REG_NUM_WIDTH]
rdData  out  NUM_RD*DATA_WIDTH  read data, same packing
rdBusy  out  NUM_RD  1 = indexed register has a pending producer
wrEnable  in  2  per-lane write enable
wrNum  in  2*REG_NUM_WIDTH  per-lane write index
wrData  in  2*DATA_WIDTH  per-lane write data
setBusyEnable  in  1  mark setBusyNum pending (issue of a new producer)
setBusyNum  in  REG_NUM_WIDTH  register to mark
busyCount  out  REG_NUM_WIDTH+1  number of busy registers

Behaviour:
- All registers update on posedge clk; reads are combinational.
- Reset (rst==0 at posedge): every storage entry <= 0, every busy bit <= 0. rdData reads 0 after reset, rdBusy 0, busyCount 0. Reset overrides any same-cycle write or set; reset mid-stream discards all pending state.
- Register 0: writes ignored, never busy; rdData for index 0 is always 0, rdBusy 0.
- Write: lane k with wrEnable[k]=1 and wrNum!=0 writes wrData at posedge. Both lanes same index: lane 1 wins; busy clear as below.
- Read without bypass: rdData shows stored value; a same-cycle write is visible the next cycle.
- Busy scoreboard: at posedge, busy[r] <= (busy[r] & ~clr[r]) | set[r]; clr[r] = any lane writing r; set[r] = setBusyEnable & setBusyNum==r & r!=0. Set and clear same register same cycle -> set wins (busy stays 1: the new producer is outstanding).
- Writes to a non-busy register are legal and clear nothing extra.
- rdBusy[i] = busy[rdNum_i] (registered state, no same-cycle clear forwarding unless bypass enabled).
- busyCount: population count of busy bits, combinational from registered state; range 0..NUM_REGS-1.
- No X propagation: out-of-range indices impossible by width (NUM_REGS power of two).

Optional Feature:
REGFILE_BYPASS_EN
- Defined: read port i with rdNum_i!=0 matching a same-cycle enabled write lane returns that wrData (lane 1 priority over lane 0, then storage); rdBusy[i] returns 0 if that write clears the register this cycle and no same-cycle set targets it. Zero-latency write-to-read.
- Undefined: plain storage read; writes visible one cycle later; rdBusy from registered state only.

Decomposition:
- Shared package (Types.v extension): DATA_WIDTH, NUM_REGS, REG_NUM_WIDTH defines, `DataPath/`RegNumPath types, zero-register constant.
- One sub-module natural: reg_busy_table (busy bits, set/clear priority, popcount); storage and read/bypass muxes stay in reg_file_mp.

Test Plan:
- Reset: write r5=0x1234, hold rst=0 one cycle -> all rdData 0, rdBusy 0, busyCount 0.
- Dual write: lane0 r3=0xA, lane1 r4=0xB same cycle; next cycle 4 ports read r3,r4,r0,r3 -> 0xA,0xB,0,0xA; write r0=0xFF -> r0 reads 0.
- Lane conflict: lane0 r7=0x11, lane1 r7=0x22 same cycle -> r7 reads 0x22.
- Scoreboard: setBusy r9 -> next cycle rdBusy=1, busyCount=1; write r9 with setBusy r9 same cycle -> still busy; write r9 alone -> busy 0, busyCount 0; setBusy r0 -> busyCount stays 0.
- Bypass (macro on): write r2=0x55 while port0 reads r2 -> rdData=0x55 same cycle; macro off -> old value this cycle, 0x55 next.
- Fill: setBusy r1..r31 over 31 cycles -> busyCount=31; reset -> 0.

Source files
------------

// File: rtl/reg_file_mp_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_mp_pkg
// Shared constants for the multi-port register file and its busy scoreboard.
//   DEF_DATA_WIDTH / DEF_NUM_REGS / DEF_NUM_RD : default geometry
//   NUM_WR                                     : number of writeback lanes
//   ZERO_REG                                   : hardwired-zero register index
// -----------------------------------------------------------------------------
package reg_file_mp_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REGS   = 32;
  localparam int DEF_NUM_RD     = 4;
  localparam int NUM_WR         = 2;
  localparam int ZERO_REG       = 0;

  typedef logic [DEF_DATA_WIDTH-1:0]       data_t;
  typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_num_t;

endpackage

// File: rtl/reg_file_mp_busy.sv
// -----------------------------------------------------------------------------
// reg_busy_table
// Per-register pending-producer scoreboard with set-over-clear priority and a
// population count of outstanding producers.
// Optional feature macro: REGFILE_BYPASS_EN (o_busy_view forwards this cycle's
// writeback clears so decode sees the register free with zero latency).
// Ports:
//   clk, rst         : clock, synchronous active-low reset
//   i_wr_en/i_wr_num : writeback lanes; each enabled lane clears its register
//   i_set_en/_num    : issue of a new producer; marks the register busy
//   o_busy_view      : busy bits as seen by the read ports
//   o_busy_count     : number of busy registers (registered state)
// -----------------------------------------------------------------------------
module reg_busy_table
  import reg_file_mp_pkg::*;
#(
  parameter  int NUM_REGS      = DEF_NUM_REGS,
  localparam int REG_NUM_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_WR-1:0]               i_wr_en,
  input  logic [NUM_WR*REG_NUM_WIDTH-1:0] i_wr_num,
  input  logic                            i_set_en,
  input  logic [REG_NUM_WIDTH-1:0]        i_set_num,
  output logic [NUM_REGS-1:0]             o_busy_view,
  output logic [REG_NUM_WIDTH:0]          o_busy_count
);

  logic [NUM_REGS-1:0]    r_busy;
  logic [NUM_REGS-1:0]    w_clr;
  logic [NUM_REGS-1:0]    w_set;
  logic [REG_NUM_WIDTH:0] w_count;

  // Decode of the clear and set strobes; register 0 is skipped so it can
  // never become busy.
  // NOTE: defaults assigned first so every path drives every bit -- no latch.
  always_comb begin
    w_clr = '0;
    w_set = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (i_wr_en[k] && i_wr_num[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] == REG_NUM_WIDTH'(r))
          w_clr[r] = 1'b1;
      end
      if (i_set_en && i_set_num == REG_NUM_WIDTH'(r))
        w_set[r] = 1'b1;
    end
  end

  // Set is ORed after the clear: a retiring old producer and a newly issued
  // one on the same register leave it busy.
  // NOTE: non-blocking assignments for state so all flops update together.
  always_ff @(posedge clk) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= (r_busy & ~w_clr) | w_set;
  end

  always_comb begin
    w_count = '0;
    for (int r = 0; r < NUM_REGS; r++)
      w_count = w_count + (REG_NUM_WIDTH+1)'(r_busy[r]);
  end

`ifdef REGFILE_BYPASS_EN
  assign o_busy_view = r_busy & ~(w_clr & ~w_set);
`else
  assign o_busy_view = r_busy;
`endif

  assign o_busy_count = w_count;

endmodule

// File: rtl/reg_file_mp.sv
// -----------------------------------------------------------------------------
// reg_file_mp
// N-read / 2-write register file, register 0 hardwired to zero, with a
// per-register busy scoreboard for decode-stage stalls.
// Optional feature macro: REGFILE_BYPASS_EN (same-cycle write-to-read bypass,
// lane 1 over lane 0 over storage). Undefined: writes visible next cycle.
// Ports:
//   clk, rst        : clock, synchronous active-low reset
//   rdNum/rdData    : packed read index / data, port i at slice i
//   rdBusy          : pending-producer flag per read port
//   wrEnable/wrNum/wrData : two writeback lanes, lane 1 wins on conflict
//   setBusyEnable/setBusyNum : mark a register pending
//   busyCount       : number of busy registers
// -----------------------------------------------------------------------------
module reg_file_mp
  import reg_file_mp_pkg::*;
#(
  parameter  int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter  int NUM_REGS      = DEF_NUM_REGS,
  parameter  int NUM_RD        = DEF_NUM_RD,
  localparam int REG_NUM_WIDTH = $clog2(NUM_REGS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_RD*REG_NUM_WIDTH-1:0] rdNum,
  output logic [NUM_RD*DATA_WIDTH-1:0]    rdData,
  output logic [NUM_RD-1:0]               rdBusy,
  input  logic [NUM_WR-1:0]               wrEnable,
  input  logic [NUM_WR*REG_NUM_WIDTH-1:0] wrNum,
  input  logic [NUM_WR*DATA_WIDTH-1:0]    wrData,
  input  logic                            setBusyEnable,
  input  logic [REG_NUM_WIDTH-1:0]        setBusyNum,
  output logic [REG_NUM_WIDTH:0]          busyCount
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0]   w_busy_view;

  // Lanes are visited in ascending order, so lane 1's assignment is the last
  // one scheduled and wins when both lanes target the same register.
  // NOTE: storage is reset explicitly because reads after reset must be 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wrEnable[k] && wrNum[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] != REG_NUM_WIDTH'(ZERO_REG))
          r_regs[wrNum[k*REG_NUM_WIDTH +: REG_NUM_WIDTH]] <= wrData[k*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_comb begin
    rdData = '0;
    rdBusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rdNum[i*REG_NUM_WIDTH +: REG_NUM_WIDTH] != REG_NUM_WIDTH'(ZERO_REG)) begin
        rdData[i*DATA_WIDTH +: DATA_WIDTH] = r_regs[rdNum[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]];
        rdBusy[i] = w_busy_view[rdNum[i*REG_NUM_WIDTH +: REG_NUM_WIDTH]];
`ifdef REGFILE_BYPASS_EN
        // Later lane overrides earlier, giving lane 1 priority.
        for (int k = 0; k < NUM_WR; k++) begin
          if (wrEnable[k] &&
              wrNum[k*REG_NUM_WIDTH +: REG_NUM_WIDTH] == rdNum[i*REG_NUM_WIDTH +: REG_NUM_WIDTH])
            rdData[i*DATA_WIDTH +: DATA_WIDTH] = wrData[k*DATA_WIDTH +: DATA_WIDTH];
        end
`endif
      end
    end
  end

  reg_busy_table #(.NUM_REGS(NUM_REGS)) u_busy (
    .clk          (clk),
    .rst          (rst),
    .i_wr_en      (wrEnable),
    .i_wr_num     (wrNum),
    .i_set_en     (setBusyEnable),
    .i_set_num    (setBusyNum),
    .o_busy_view  (w_busy_view),
    .o_busy_count (busyCount)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int DW  = 32;
  localparam int NR  = 32;
  localparam int NRD = 4;
  localparam int RW  = $clog2(NR);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [NRD*RW-1:0] rdNum;
  logic [NRD*DW-1:0] rdData;
  logic [NRD-1:0]  rdBusy;
  logic [1:0]      wrEnable;
  logic [2*RW-1:0] wrNum;
  logic [2*DW-1:0] wrData;
  logic            setBusyEnable;
  logic [RW-1:0]   setBusyNum;
  logic [RW:0]     busyCount;

  reg_file_mp #(.DATA_WIDTH(DW), .NUM_REGS(NR), .NUM_RD(NRD)) dut (
    .clk           (clk),
    .rst           (rst),
    .rdNum         (rdNum),
    .rdData        (rdData),
    .rdBusy        (rdBusy),
    .wrEnable      (wrEnable),
    .wrNum         (wrNum),
    .wrData        (wrData),
    .setBusyEnable (setBusyEnable),
    .setBusyNum    (setBusyNum),
    .busyCount     (busyCount)
  );

  typedef struct {
    logic [NRD*DW-1:0] data;
    logic [NRD-1:0]    busy;
    int                cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model: architectural register contents and pending flags.
  logic [DW-1:0] m_mem [NR];
  bit            m_busy [NR];
  int            t_rn [NRD];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus: drive inputs, queue the outputs the model predicts
  // for this cycle, then advance the model past the coming edge.
  task automatic step(input bit r, input bit we0, input int wn0, input logic [DW-1:0] wd0,
                      input bit we1, input int wn1, input logic [DW-1:0] wd1,
                      input bit se, input int sn);
    exp_t e;
    @(posedge clk);
    #1;
    rst           = r;
    wrEnable      = {we1, we0};
    wrNum         = {RW'(wn1), RW'(wn0)};
    wrData        = {wd1, wd0};
    setBusyEnable = se;
    setBusyNum    = RW'(sn);
    for (int i = 0; i < NRD; i++) rdNum[i*RW +: RW] = RW'(t_rn[i]);

    e.data = '0;
    e.busy = '0;
    e.cnt  = 0;
    for (int x = 0; x < NR; x++) if (m_busy[x]) e.cnt++;
    for (int i = 0; i < NRD; i++) begin
      int n;
      n = t_rn[i];
      if (n != 0) begin
        logic [DW-1:0] d;
        bit b;
        d = m_mem[n];
        b = m_busy[n];
`ifdef REGFILE_BYPASS_EN
        if (we1 && wn1 == n) d = wd1;
        else if (we0 && wn0 == n) d = wd0;
        if (((we0 && wn0 == n) || (we1 && wn1 == n)) && !(se && sn == n)) b = 0;
`endif
        e.data[i*DW +: DW] = d;
        e.busy[i] = b;
      end
    end
    q.push_back(e);

    if (!r) begin
      for (int x = 0; x < NR; x++) begin
        m_mem[x]  = '0;
        m_busy[x] = 0;
      end
    end else begin
      if (we0 && wn0 != 0) m_mem[wn0] = wd0;
      if (we1 && wn1 != 0) m_mem[wn1] = wd1;
      if (we0) m_busy[wn0] = 0;
      if (we1) m_busy[wn1] = 0;
      if (se && sn != 0) m_busy[sn] = 1;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // Monitor: the read side is valid every cycle, so one expectation is
  // retired per falling edge.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      mon_e = q.pop_front();
      for (int i = 0; i < NRD; i++) begin
        check($sformatf("rdData[%0d]", i), 64'(rdData[i*DW +: DW]), 64'(mon_e.data[i*DW +: DW]));
        check($sformatf("rdBusy[%0d]", i), 64'(rdBusy[i]), 64'(mon_e.busy[i]));
      end
      check("busyCount", 64'(busyCount), 64'(mon_e.cnt));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int x = 0; x < NR; x++) begin
      m_mem[x]  = '0;
      m_busy[x] = 0;
    end
    for (int i = 0; i < NRD; i++) t_rn[i] = 0;
    rst = 1'b0; wrEnable = '0; wrNum = '0; wrData = '0;
    setBusyEnable = 1'b0; setBusyNum = '0; rdNum = '0;
    repeat (2) @(posedge clk);

    // Reset discards a prior write and overrides a same-cycle write.
    step(1, 1, 5, 32'h1234, 0, 0, '0, 1, 5);
    for (int i = 0; i < NRD; i++) t_rn[i] = 5;
    step(0, 1, 5, 32'h1234, 0, 0, '0, 1, 6);
    idle(); settle();
    check("reset_rd5", 64'(rdData[DW-1:0]), 64'h0);
    check("reset_busy", 64'(rdBusy), 64'h0);
    check("reset_cnt", 64'(busyCount), 64'h0);

    // Dual write, then four ports read r3,r4,r0,r3.
    step(1, 1, 3, 32'hA, 1, 4, 32'hB, 0, 0);
    t_rn[0] = 3; t_rn[1] = 4; t_rn[2] = 0; t_rn[3] = 3;
    idle(); settle();
    check("dual_rd", 64'(rdData), 64'(128'h0000000A_00000000_0000000B_0000000A));
    for (int i = 0; i < NRD; i++) t_rn[i] = 0;
    step(1, 1, 0, 32'hFF, 0, 0, '0, 0, 0);
    idle(); settle();
    check("r0_zero", 64'(rdData[DW-1:0]), 64'h0);

    // Lane conflict: lane 1 wins.
    step(1, 1, 7, 32'h11, 1, 7, 32'h22, 0, 0);
    t_rn[0] = 7;
    idle(); settle();
    check("conflict_r7", 64'(rdData[DW-1:0]), 64'h22);

    // Scoreboard set / clear priority.
    t_rn[0] = 9;
    step(1, 0, 0, '0, 0, 0, '0, 1, 9);
    idle(); settle();
    check("sb_set_busy", 64'(rdBusy[0]), 64'h1);
    check("sb_set_cnt", 64'(busyCount), 64'h1);
    step(1, 1, 9, 32'h99, 0, 0, '0, 1, 9);
    idle(); settle();
    check("sb_set_wins", 64'(rdBusy[0]), 64'h1);
    step(1, 0, 0, '0, 1, 9, 32'h98, 0, 0);
    idle(); settle();
    check("sb_clr_busy", 64'(rdBusy[0]), 64'h0);
    check("sb_clr_cnt", 64'(busyCount), 64'h0);
    step(1, 0, 0, '0, 0, 0, '0, 1, 0);
    idle(); settle();
    check("sb_r0_cnt", 64'(busyCount), 64'h0);

    // Fill every register, then reset.
    for (int r = 1; r < NR; r++) step(1, 0, 0, '0, 0, 0, '0, 1, r);
    idle(); settle();
    check("fill_cnt", 64'(busyCount), 64'(NR-1));
    step(0, 0, 0, '0, 0, 0, '0, 0, 0);
    idle(); settle();
    check("fill_reset_cnt", 64'(busyCount), 64'h0);

    // Write-to-read timing on r2 (zero after the reset above).
    t_rn[0] = 2;
    step(1, 1, 2, 32'h55, 0, 0, '0, 0, 0);
    settle();
`ifdef REGFILE_BYPASS_EN
    check("bypass_same", 64'(rdData[DW-1:0]), 64'h55);
`else
    check("nobypass_same", 64'(rdData[DW-1:0]), 64'h0);
`endif
    idle(); settle();
    check("write_next", 64'(rdData[DW-1:0]), 64'h55);

    // Randomized traffic; small index range half the time to force collisions.
    for (int c = 0; c < 600; c++) begin
      int hi;
      hi = ($urandom_range(0, 1) == 0) ? 7 : NR - 1;
      for (int i = 0; i < NRD; i++) t_rn[i] = int'($urandom_range(0, hi));
      step(($urandom_range(0, 63) != 0),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, hi)), DW'($urandom),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, hi)), DW'($urandom),
           bit'($urandom_range(0, 1)), int'($urandom_range(0, hi)));
    end

    idle(); settle();
    check("queue_drained", 64'(q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
